key_scan_mux: RTL and testbench

//  Parametrised key-entry and 7-seg display controller. Debounces N_KEYS active-low buttons,

---
 rtl/key_scan_mux.sv | 162 ++++++++++++++++
 tb/tb_key_scan_mux.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_mux.sv
// Debounced key entry that edits a hex buffer under a cursor, time-multiplexed onto 7-seg lines.
// Define KEY_SCAN_BLINK_EN to blank the cursor digit on a periodic blink phase.
module key_scan_mux #(
  parameter int F_CLK        = 50000000,
  parameter int F_SCAN       = 1000,
  parameter int N_KEYS       = 6,
  parameter int N_DIGITS     = 8,
  parameter int DEB_CYCLES   = 1000000,
  parameter int BLINK_CYCLES = 12500000,
  localparam int CW          = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_KEYS-1:0]     key,
  output logic [N_KEYS-1:0]     key_press,
  output logic [CW-1:0]         cursor,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   dots,
  output logic [7:0]            cs,
  output logic [7:0]            o_dig_sel
);
  localparam int SCAN_DIV = F_CLK / F_SCAN;
  localparam int PW       = $clog2(SCAN_DIV);
  localparam int DW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST_DIG = CW'(N_DIGITS - 1);

  logic [N_KEYS-1:0]          sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
  logic [N_KEYS-1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [N_KEYS-1:0]          key_press_q, key_press_d;
  logic [CW-1:0]              cursor_q, cursor_d;
  logic [N_DIGITS-1:0][3:0]   digits_q, digits_d;
  logic [N_DIGITS-1:0]        dots_q, dots_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic [CW-1:0]              idx_q, idx_d, disp_idx_q, disp_idx_d;
  logic [7:0]                 seg_q, seg_d, cs_q, cs_d, dig_sel_q, dig_sel_d;
  logic                       edit_act, blank;
`ifdef KEY_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES);
  logic [BW-1:0]              blk_cnt_q, blk_cnt_d;
  logic                       phase_q, phase_d;
`endif

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'h40;  4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;  4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;  4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;  4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;  4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;  4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;  4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;  default: hex_font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    sync1_d     = key;
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    deb_cnt_d   = deb_cnt_q;
    key_press_d = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (sync2_q[k] == stable_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) begin
        deb_cnt_d[k]   = '0;
        stable_d[k]    = sync2_q[k];
        key_press_d[k] = ~sync2_q[k];
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
      end
    end

    // One edit per cycle; lower-priority pulses in the same cycle are dropped.
    cursor_d = cursor_q;
    digits_d = digits_q;
    dots_d   = dots_q;
    edit_act = |key_press_q[4:0];
    if (key_press_q[0])
      cursor_d = (cursor_q == LAST_DIG) ? '0 : cursor_q + CW'(1);
    else if (key_press_q[1])
      cursor_d = (cursor_q == '0) ? LAST_DIG : cursor_q - CW'(1);
    else if (key_press_q[2])
      digits_d[cursor_q] = digits_q[cursor_q] + 4'd1;
    else if (key_press_q[3])
      digits_d[cursor_q] = digits_q[cursor_q] - 4'd1;
    else if (key_press_q[4])
      dots_d[cursor_q] = ~dots_q[cursor_q];

    presc_d = (presc_q == PW'(SCAN_DIV - 1)) ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1))
      idx_d = (idx_q == LAST_DIG) ? '0 : idx_q + CW'(1);

    // Segment pattern is captured once at the start of each slot so edits never tear a slot.
    disp_idx_d = (presc_q == '0) ? idx_q : disp_idx_q;
    seg_d      = (presc_q == '0) ? {~dots_q[idx_q], hex_font(digits_q[idx_q])} : seg_q;
    cs_d       = ~(8'h01 << disp_idx_d);

`ifdef KEY_SCAN_BLINK_EN
    blk_cnt_d = (blk_cnt_q == BW'(BLINK_CYCLES - 1)) ? '0 : blk_cnt_q + BW'(1);
    phase_d   = (blk_cnt_q == BW'(BLINK_CYCLES - 1)) ? ~phase_q : phase_q;
    if (edit_act) begin
      blk_cnt_d = '0;
      phase_d   = 1'b1;
    end
    blank = ~phase_d && (disp_idx_d == cursor_d);
`else
    blank = 1'b0;
`endif
    dig_sel_d = blank ? 8'hFF : seg_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      stable_q    <= '1;
      deb_cnt_q   <= '0;
      key_press_q <= '0;
      cursor_q    <= '0;
      digits_q    <= '0;
      dots_q      <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      disp_idx_q  <= '0;
      seg_q       <= 8'hFF;
      cs_q        <= 8'hFF;
      dig_sel_q   <= 8'hFF;
`ifdef KEY_SCAN_BLINK_EN
      blk_cnt_q   <= '0;
      phase_q     <= 1'b1;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      deb_cnt_q   <= deb_cnt_d;
      key_press_q <= key_press_d;
      cursor_q    <= cursor_d;
      digits_q    <= digits_d;
      dots_q      <= dots_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_idx_q  <= disp_idx_d;
      seg_q       <= seg_d;
      cs_q        <= cs_d;
      dig_sel_q   <= dig_sel_d;
`ifdef KEY_SCAN_BLINK_EN
      blk_cnt_q   <= blk_cnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

  assign key_press = key_press_q;
  assign cursor    = cursor_q;
  assign digits    = digits_q;
  assign dots      = dots_q;
  assign cs        = cs_q;
  assign o_dig_sel = dig_sel_q;
endmodule

// File: tb/tb_key_scan_mux.sv
// Directed bench for key_scan_mux: reset, debounce, edit wraps, priority, dots, scan and blink.
module tb_key_scan_mux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  key;
  logic [5:0]  key_press;
  logic [2:0]  cursor;
  logic [31:0] digits;
  logic [7:0]  dots;
  logic [7:0]  cs;
  logic [7:0]  o_dig_sel;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef KEY_SCAN_BLINK_EN
  localparam logic [7:0] BLANK_EXP = 8'hFF;
`else
  localparam logic [7:0] BLANK_EXP = 8'hC0;
`endif

  key_scan_mux #(
    .F_CLK(1000), .F_SCAN(100), .N_KEYS(6), .N_DIGITS(8),
    .DEB_CYCLES(4), .BLINK_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_press(key_press), .cursor(cursor),
    .digits(digits), .dots(dots), .cs(cs), .o_dig_sel(o_dig_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold keys in mask low until the edit action edge; key_press seen on the way is returned.
  task automatic press(input logic [5:0] m, output logic [5:0] seen);
    seen = '0;
    key  = ~m;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen |= key_press;
    end
    key = '1;
  endtask

  task automatic settle();
    for (int i = 0; i < 10; i++) tick();
  endtask

  // Advance to the first cycle of a fresh slot showing the given select pattern.
  task automatic wait_fresh(input string tag, input logic [7:0] val);
    int n = 0;
    while (cs === val && n < 200) begin tick(); n++; end
    while (cs !== val && n < 400) begin tick(); n++; end
    chk(tag, {24'h0, cs}, {24'h0, val});
  endtask

  logic [5:0] kp;
  int first, npulse, a;

  initial begin
    rst_n = 1'b0;
    key   = '1;
    // Reset and scan timing
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_cs", {24'h0, cs}, 32'hFF);
    end
    chk("rst_seg", {24'h0, o_dig_sel}, 32'hFF);
    chk("rst_kp", {26'h0, key_press}, 32'h0);
    chk("rst_cursor", {29'h0, cursor}, 32'h0);
    chk("rst_digits", digits, 32'h0);
    chk("rst_dots", {24'h0, dots}, 32'h0);
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    chk("scan_first_cs", {24'h0, cs}, 32'hFE);
    chk("scan_first_seg", {24'h0, o_dig_sel}, 32'hC0);
    tick_to(10); chk("scan_hold_cs", {24'h0, cs}, 32'hFE);
    tick_to(11); chk("scan_adv_cs", {24'h0, cs}, 32'hFD);
    tick_to(80); chk("scan_last_cs", {24'h0, cs}, 32'h7F);
    tick_to(81); chk("scan_wrap_cs", {24'h0, cs}, 32'hFE);

    // Debounce: short glitch ignored, long press gives one pulse after 6 cycles
    npulse = 0;
    key[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); npulse += int'(key_press[2]); end
    key[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); npulse += int'(key_press[2]); end
    chk("glitch_pulses", npulse, 0);
    first = 0; npulse = 0; kp = '0;
    key[2] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (key_press != 0 && first == 0) begin first = i; kp = key_press; end
      npulse += int'(key_press[2]);
    end
    key[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); npulse += int'(key_press[2]); end
    chk("deb_latency", first, 6);
    chk("deb_pulses", npulse, 1);
    chk("deb_kp", {26'h0, kp}, 32'h04);
    chk("inc_digit0", digits, 32'h0000_0001);

    // Wraps: PREV from 0, DEC from 0
    press(6'b000010, kp); settle();
    chk("prev_wrap", {29'h0, cursor}, 32'd7);
    press(6'b001000, kp); settle();
    chk("dec_wrap", digits, 32'hF000_0001);
    // Toggle dot 7 during slot 6 so slot 7 is fresh and unblanked
    wait_fresh("wait_slot6a", 8'hBF);
    press(6'b010000, kp);
    wait_fresh("wait_slot7a", 8'h7F);
    chk("slot7_dp_seg", {24'h0, o_dig_sel}, 32'h0E);
    chk("dot7_set", {24'h0, dots}, 32'h80);
    settle();
    wait_fresh("wait_slot6b", 8'hBF);
    press(6'b010000, kp);
    wait_fresh("wait_slot7b", 8'h7F);
    chk("slot7_seg", {24'h0, o_dig_sel}, 32'h8E);
    chk("dot7_clr", {24'h0, dots}, 32'h00);
    settle();

    // Priority: NEXT and INC together, only NEXT acts (cursor 7 wraps to 0)
    press(6'b000101, kp); settle();
    chk("prio_kp", {26'h0, kp}, 32'h05);
    chk("prio_cursor", {29'h0, cursor}, 32'd0);
    chk("prio_digits", digits, 32'hF000_0001);

    // DEC digit 0 back to 0, dot on digit 0, spare key
    press(6'b001000, kp); settle();
    chk("dec_digit0", digits, 32'hF000_0000);
    wait_fresh("wait_slot7c", 8'h7F);
    press(6'b010000, kp);
    wait_fresh("wait_slot0a", 8'hFE);
    chk("slot0_dp_seg", {24'h0, o_dig_sel}, 32'h40);
    chk("dot0_set", {24'h0, dots}, 32'h01);
    settle();
    press(6'b100000, kp); settle();
    chk("spare_kp", {26'h0, kp}, 32'h20);
    chk("spare_cursor", {29'h0, cursor}, 32'd0);
    chk("spare_digits", digits, 32'hF000_0000);
    chk("spare_dots", {24'h0, dots}, 32'h01);

    // Blink: edit action at edge a restarts the phase; slot 0 occupies a+3+80k .. a+12+80k
    wait_fresh("wait_slot7d", 8'h7F);
    press(6'b010000, kp);
    a = cyc;
    tick_to(a + 5);   chk("blink_vis0", {24'h0, o_dig_sel}, 32'hC0);
    tick_to(a + 85);  chk("blink_blank1", {24'h0, o_dig_sel}, {24'h0, BLANK_EXP});
    tick_to(a + 245); chk("blink_vis3", {24'h0, o_dig_sel}, 32'hC0);
    tick_to(a + 251); chk("blink_blank3", {24'h0, o_dig_sel}, {24'h0, BLANK_EXP});
    tick_to(a + 480);
    key[2] = 1'b0;
    tick_to(a + 486); chk("blink_blank6", {24'h0, o_dig_sel}, {24'h0, BLANK_EXP});
    tick_to(a + 487); chk("blink_edit_vis", {24'h0, o_dig_sel}, 32'hC0);
    key = '1;
    settle();
    chk("blink_inc", digits, 32'hF000_0001);

    // Key held through reset: state cleared, one press 6 cycles after release
    key[5] = 1'b0;
    rst_n  = 1'b0;
    tick(); tick();
    chk("rst2_cs", {24'h0, cs}, 32'hFF);
    chk("rst2_kp", {26'h0, key_press}, 32'h0);
    rst_n = 1'b1;
    first = 0; npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (key_press[5] && first == 0) first = i;
      npulse += int'(key_press[5]);
    end
    chk("rst2_latency", first, 6);
    chk("rst2_pulses", npulse, 1);
    chk("rst2_digits", digits, 32'h0);
    chk("rst2_cursor", {29'h0, cursor}, 32'h0);
    chk("rst2_dots", {24'h0, dots}, 32'h0);
    key = '1;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
